// File: rtl/hazard_ctrl.sv
// Load-use / branch-flush / dmem-freeze controller for the five-stage core, with a dmem watchdog.
// Optional performance counters are enabled by defining HAZ_PERF_CNT_EN.
module hazard_ctrl #(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 5
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ID_EX_MemRead,
  input  logic [4:0] ID_EX_Rd,
  input  logic [4:0] IF_ID_Rs1,
  input  logic [4:0] IF_ID_Rs2,
  input  logic       IF_ID_UsesRs2,
  input  logic       branch_taken,
  input  logic       dmem_req,
  input  logic       dmem_ready,
  output logic       pc_en,
  output logic       IF_ID_en,
  output logic       IF_ID_flush,
  output logic       ID_EX_en,
  output logic       ID_EX_flush,
  output logic       EX_MEM_en,
  output logic       MEM_WB_bubble,
  output logic       mem_timeout
`ifdef HAZ_PERF_CNT_EN
  ,
  output logic [31:0] stall_cycles,
  output logic [31:0] flush_count
`endif
);

  // state   | meaning
  // ST_RUN  | pipeline flowing; load-use and branch handling active
  // ST_WAIT | dmem request outstanding; pipeline frozen, watchdog counting
  // ST_ERR  | watchdog expired; frozen until reset
  typedef enum logic [1:0] {ST_RUN, ST_WAIT, ST_ERR} state_t;

  state_t             state_q, state_d, state_eff;
  logic [CNT_W-1:0]   wait_cnt_q, wait_cnt_d;
  logic               mem_timeout_q, mem_timeout_d;
  logic               freeze, load_use;

  assign freeze   = dmem_req & ~dmem_ready;
  assign load_use = ID_EX_MemRead & (ID_EX_Rd != 5'd0) &
                    ((ID_EX_Rd == IF_ID_Rs1) | (IF_ID_UsesRs2 & (ID_EX_Rd == IF_ID_Rs2)));

  // During reset the outputs behave as in RUN so the core sees sane enables.
  assign state_eff   = rst_n ? state_q : ST_RUN;
  assign mem_timeout = mem_timeout_q;

  always_comb begin
    pc_en         = 1'b1;
    IF_ID_en      = 1'b1;
    IF_ID_flush   = 1'b0;
    ID_EX_en      = 1'b1;
    ID_EX_flush   = 1'b0;
    EX_MEM_en     = 1'b1;
    MEM_WB_bubble = 1'b0;
    if ((state_eff == ST_ERR) || freeze) begin
      pc_en         = 1'b0;
      IF_ID_en      = 1'b0;
      ID_EX_en      = 1'b0;
      EX_MEM_en     = 1'b0;
      MEM_WB_bubble = 1'b1;
    end else if (branch_taken) begin
      IF_ID_flush = 1'b1;
      ID_EX_flush = 1'b1;
    end else if (load_use) begin
      pc_en       = 1'b0;
      IF_ID_en    = 1'b0;
      ID_EX_flush = 1'b1;
    end
  end

  always_comb begin
    state_d       = state_q;
    wait_cnt_d    = wait_cnt_q;
    mem_timeout_d = mem_timeout_q;
    case (state_q)
      ST_RUN: begin
        if (freeze) begin
          state_d    = ST_WAIT;
          wait_cnt_d = CNT_W'(1);
        end
      end
      ST_WAIT: begin
        if (!freeze) begin
          state_d    = ST_RUN;
          wait_cnt_d = '0;
        end else if (int'(wait_cnt_q) + 1 >= MEM_TIMEOUT) begin
          // The cycle that brings the count to MEM_TIMEOUT trips the watchdog.
          state_d       = ST_ERR;
          mem_timeout_d = 1'b1;
          wait_cnt_d    = CNT_W'(MEM_TIMEOUT);
        end else if (wait_cnt_q != {CNT_W{1'b1}}) begin
          wait_cnt_d = wait_cnt_q + 1'b1;
        end
      end
      ST_ERR:  state_d = ST_ERR;
      default: state_d = ST_RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= ST_RUN;
      wait_cnt_q    <= '0;
      mem_timeout_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      wait_cnt_q    <= wait_cnt_d;
      mem_timeout_q <= mem_timeout_d;
    end
  end

`ifdef HAZ_PERF_CNT_EN
  logic [31:0] stall_cycles_q, stall_cycles_d;
  logic [31:0] flush_count_q, flush_count_d;

  // IF_ID_flush is asserted only when a branch is honoured.
  always_comb begin
    stall_cycles_d = stall_cycles_q + {31'd0, ~pc_en};
    flush_count_d  = flush_count_q + {31'd0, IF_ID_flush};
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stall_cycles_q <= '0;
      flush_count_q  <= '0;
    end else begin
      stall_cycles_q <= stall_cycles_d;
      flush_count_q  <= flush_count_d;
    end
  end

  assign stall_cycles = stall_cycles_q;
  assign flush_count  = flush_count_q;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Scoreboard bench for hazard_ctrl: driver queues expected output vectors, a negedge monitor checks them.
module tb_hazard_ctrl;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       ID_EX_MemRead = 1'b0;
  logic [4:0] ID_EX_Rd = 5'd0, IF_ID_Rs1 = 5'd0, IF_ID_Rs2 = 5'd0;
  logic       IF_ID_UsesRs2 = 1'b0, branch_taken = 1'b0, dmem_req = 1'b0, dmem_ready = 1'b0;
  logic       pc_en, IF_ID_en, IF_ID_flush, ID_EX_en, ID_EX_flush, EX_MEM_en, MEM_WB_bubble, mem_timeout;
`ifdef HAZ_PERF_CNT_EN
  logic [31:0] stall_cycles, flush_count;
`endif

  hazard_ctrl #(.MEM_TIMEOUT(16), .CNT_W(5)) dut (
    .clk(clk), .rst_n(rst_n),
    .ID_EX_MemRead(ID_EX_MemRead), .ID_EX_Rd(ID_EX_Rd),
    .IF_ID_Rs1(IF_ID_Rs1), .IF_ID_Rs2(IF_ID_Rs2), .IF_ID_UsesRs2(IF_ID_UsesRs2),
    .branch_taken(branch_taken), .dmem_req(dmem_req), .dmem_ready(dmem_ready),
    .pc_en(pc_en), .IF_ID_en(IF_ID_en), .IF_ID_flush(IF_ID_flush), .ID_EX_en(ID_EX_en),
    .ID_EX_flush(ID_EX_flush), .EX_MEM_en(EX_MEM_en), .MEM_WB_bubble(MEM_WB_bubble),
    .mem_timeout(mem_timeout)
`ifdef HAZ_PERF_CNT_EN
    , .stall_cycles(stall_cycles), .flush_count(flush_count)
`endif
  );

  always #5 clk = ~clk;

  // Vector order: pc_en IF_ID_en IF_ID_flush ID_EX_en ID_EX_flush EX_MEM_en MEM_WB_bubble mem_timeout
  localparam logic [7:0] DEF = 8'b1101_0100;
  localparam logic [7:0] LU  = 8'b0001_1100;
  localparam logic [7:0] BR  = 8'b1111_1100;
  localparam logic [7:0] FRZ = 8'b0000_0010;
  localparam logic [7:0] ERR = 8'b0000_0011;

  typedef struct { logic [7:0] v; string tag; } exp_t;
  exp_t q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic drive(input logic r, input logic mr, input logic [4:0] rd, input logic [4:0] rs1,
                       input logic [4:0] rs2, input logic u2, input logic bt, input logic req,
                       input logic rdy, input logic [7:0] ev, input string tag, input bit chk);
    @(posedge clk); #1;
    rst_n = r; ID_EX_MemRead = mr; ID_EX_Rd = rd; IF_ID_Rs1 = rs1; IF_ID_Rs2 = rs2;
    IF_ID_UsesRs2 = u2; branch_taken = bt; dmem_req = req; dmem_ready = rdy;
    if (chk) q.push_back('{v: ev, tag: tag});
  endtask

  task automatic idle(input logic [7:0] ev, input string tag);
    drive(1, 0, 0, 0, 0, 0, 0, 0, 0, ev, tag, 1);
  endtask

  always @(negedge clk) begin
    logic [7:0] got;
    exp_t       e;
    if (q.size() > 0) begin
      e   = q.pop_front();
      got = {pc_en, IF_ID_en, IF_ID_flush, ID_EX_en, ID_EX_flush, EX_MEM_en, MEM_WB_bubble, mem_timeout};
      n_cmp++;
      if (got !== e.v) begin
        n_bad++;
        $display("FAIL %s: got %b required %b", e.tag, got, e.v);
      end
    end
  end

  initial begin
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, DEF, "reset_idle", 1);
    drive(0, 0, 0, 0, 0, 0, 0, 1, 0, FRZ, "reset_freeze_eq", 1);
    idle(DEF, "post_reset");

    drive(1, 1, 5, 5, 0, 0, 0, 0, 0, LU,  "load_use_rs1", 1);
    idle(DEF, "load_use_one_cycle");
    drive(1, 1, 0, 0, 0, 0, 0, 0, 0, DEF, "load_x0", 1);
    drive(1, 1, 7, 3, 7, 0, 0, 0, 0, DEF, "rs2_unused", 1);
    drive(1, 1, 7, 3, 7, 1, 0, 0, 0, LU,  "rs2_used", 1);
    drive(1, 1, 5, 5, 0, 0, 1, 0, 0, BR,  "branch_over_lu", 1);
    drive(1, 0, 0, 0, 0, 0, 1, 0, 0, BR,  "branch_only", 1);

    drive(1, 0, 0, 0, 0, 0, 0, 1, 0, FRZ, "mem_wait1", 1);
    drive(1, 1, 5, 5, 0, 0, 1, 1, 0, FRZ, "mem_wait2_br_lu", 1);
    drive(1, 0, 0, 0, 0, 0, 0, 1, 0, FRZ, "mem_wait3", 1);
    drive(1, 0, 0, 0, 0, 0, 0, 1, 1, DEF, "mem_ready", 1);
    idle(DEF, "mem_back_run");
    drive(1, 0, 0, 0, 0, 0, 0, 1, 0, FRZ, "b2b_wait_a", 1);
    drive(1, 0, 0, 0, 0, 0, 0, 1, 1, DEF, "b2b_ready_a", 1);
    drive(1, 0, 0, 0, 0, 0, 0, 1, 0, FRZ, "b2b_wait_b", 1);
    drive(1, 0, 0, 0, 0, 0, 0, 0, 0, DEF, "b2b_req_drop", 1);

    for (int i = 1; i <= 16; i++)
      drive(1, 0, 0, 0, 0, 0, 0, 1, 0, FRZ, $sformatf("timeout_wait%0d", i), 1);
    drive(1, 0, 0, 0, 0, 0, 0, 1, 1, ERR, "err_ready_ignored", 1);
    drive(1, 1, 5, 5, 0, 0, 1, 0, 0, ERR, "err_sticky", 1);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, DEF, "err_reset", 0);
    idle(DEF, "err_cleared");

    idle(DEF, "perf_lead");
    drive(1, 1, 5, 5, 0, 0, 0, 0, 0, LU,  "perf_lu", 1);
    drive(1, 0, 0, 0, 0, 0, 1, 0, 0, BR,  "perf_br", 1);
    drive(1, 0, 0, 0, 0, 0, 0, 1, 0, FRZ, "perf_wait1", 1);
    drive(1, 0, 0, 0, 0, 0, 0, 1, 0, FRZ, "perf_wait2", 1);
    drive(1, 0, 0, 0, 0, 0, 0, 1, 0, FRZ, "perf_wait3", 1);
    drive(1, 0, 0, 0, 0, 0, 0, 1, 1, DEF, "perf_ready", 1);
    idle(DEF, "perf_tail");
    @(posedge clk); #1;
`ifdef HAZ_PERF_CNT_EN
    n_cmp++;
    if (stall_cycles !== 32'd4) begin
      n_bad++;
      $display("FAIL stall_cycles: got %0d required 4", stall_cycles);
    end
    n_cmp++;
    if (flush_count !== 32'd1) begin
      n_bad++;
      $display("FAIL flush_count: got %0d required 1", flush_count);
    end
`endif

    for (int i = 0; i < 10 && q.size() > 0; i++) @(negedge clk);
    #1;
    if (q.size() > 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL scoreboard_drain: got %0d pending required 0", q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
